// File: rtl/char_buf_if.sv
// char_buf_if -- command and read-port bundle for char_buf_writer.
//
// Handshake: a command transfers on a rising clock edge where cmd_valid and
// cmd_ready are both high; cmd_op/cmd_xy/cmd_char/cmd_num are only looked at
// on that edge. cmd_ready is a function of block state only, never of
// cmd_valid, so the requester may hold or withdraw cmd_valid freely.
//
// Signals:
//   cmd_valid  requester -> block  command request
//   cmd_ready  block -> requester  block can accept a command this cycle
//   cmd_op     requester -> block  00 char, 01 number, 10 clear, 11 fill row
//   cmd_xy     requester -> block  target cell {row[7:4], col[3:0]}
//   cmd_char   requester -> block  character code for ops 00 and 11
//   cmd_num    requester -> block  unsigned value for op 01
//   rd_xy      renderer -> block   read address {row, col}
//   rd_code    block -> renderer   registered character code at rd_xy
//   busy       block -> requester  multi-cycle op in progress (~cmd_ready)
interface char_buf_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_xy;
    logic [6:0] cmd_char;
    logic [9:0] cmd_num;
    logic [7:0] rd_xy;
    logic [6:0] rd_code;
    logic       busy;

    modport master (
        output cmd_valid, cmd_op, cmd_xy, cmd_char, cmd_num, rd_xy,
        input  cmd_ready, rd_code, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_xy, cmd_char, cmd_num, rd_xy,
        output cmd_ready, rd_code, busy
    );
endinterface

// File: rtl/char_buf_writer.sv
// char_buf_writer -- 16x16 character buffer with a small command engine.
//
// Commands (through char_buf_if):
//   00 write one character at cmd_xy (single cycle, stays ready)
//   01 write cmd_num (saturated to 999) as NUM_DIGITS decimal digits starting
//      at cmd_xy, leading zeros blanked; 10 conversion cycles then one digit
//      per cycle, column wrapping inside the row
//   10 clear all 256 cells to BLANK_CODE, one per cycle
//   11 fill the 16 cells of cmd_xy's row with cmd_char, one per cycle
// The renderer port returns buffer[rd_xy] one cycle later (read-before-write).
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset, aborts any operation
//   bus        char_buf_if.slave command/read bundle
//   state_dbg  current FSM state encoding (IDLE=0 CONV=1 WNUM=2 CLEAR=3 FILL=4)
//
// Build option: define CHAR_BUF_CLEAR_ON_RESET_EN to make reset enter CLEAR,
// so the buffer is blanked automatically after every reset. Without it reset
// enters IDLE and buffer contents are whatever was there before.
module char_buf_writer #(
    parameter logic [6:0] BLANK_CODE = 7'h20,
    parameter int         NUM_DIGITS = 3
) (
    input  logic         clk,
    input  logic         rst,
    char_buf_if.slave    bus,
    output logic [2:0]   state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CONV  = 3'd1,
        S_WNUM  = 3'd2,
        S_CLEAR = 3'd3,
        S_FILL  = 3'd4
    } state_t;

    localparam logic [1:0] OP_CHAR  = 2'b00;
    localparam logic [1:0] OP_NUM   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_FILL  = 2'b11;

`ifdef CHAR_BUF_CLEAR_ON_RESET_EN
    localparam state_t RST_STATE = S_CLEAR;
`else
    localparam state_t RST_STATE = S_IDLE;
`endif

    localparam logic [7:0] CONV_LAST = 8'd9;
    localparam logic [7:0] WNUM_LAST = 8'(NUM_DIGITS - 1);

    state_t      state;
    state_t      state_nx;
    logic [7:0]  cnt;
    logic [9:0]  bin_sr;
    logic [11:0] bcd;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [6:0]  fill_char;
    logic        nz_seen;
    logic [6:0]  rd_code_q;

    logic        accept;
    logic        ready;
    logic        we;
    logic [7:0]  waddr;
    logic [6:0]  wdata;
    logic [1:0]  dpos;
    logic [3:0]  digit;
    logic        blank;

    logic [6:0]  mem [0:255];

    // Add 3 to every BCD digit >= 5; applied before each left shift.
    function automatic logic [11:0] bcd_adjust(input logic [11:0] b);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
        end
        return r;
    endfunction

    assign accept = bus.cmd_valid && ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_nx;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (bus.cmd_op)
                        OP_NUM:   state_nx = S_CONV;
                        OP_CLEAR: state_nx = S_CLEAR;
                        OP_FILL:  state_nx = S_FILL;
                        default:  state_nx = S_IDLE;
                    endcase
                end
            end
            S_CONV:  if (cnt == CONV_LAST)   state_nx = S_WNUM;
            S_WNUM:  if (cnt == WNUM_LAST)   state_nx = S_IDLE;
            S_CLEAR: if (cnt == 8'd255)      state_nx = S_IDLE;
            S_FILL:  if (cnt == 8'd15)       state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- digit selection for number writes ----------------
    // cnt walks the field most significant first; dpos is the decimal
    // position (0 = units) of the digit being written this cycle.
    always_comb begin
        dpos  = 2'(NUM_DIGITS - 1) - cnt[1:0];
        digit = 4'd0;
        case (dpos)
            2'd0:    digit = bcd[3:0];
            2'd1:    digit = bcd[7:4];
            default: digit = bcd[11:8];
        endcase
        // Units digit is always shown so a zero value still prints "0".
        blank = !nz_seen && (digit == 4'd0) && (dpos != 2'd0);
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready = (state == S_IDLE);
        we    = 1'b0;
        waddr = bus.cmd_xy;
        wdata = bus.cmd_char;
        case (state)
            S_IDLE: begin
                we    = accept && (bus.cmd_op == OP_CHAR);
                waddr = bus.cmd_xy;
                wdata = bus.cmd_char;
            end
            S_WNUM: begin
                we    = 1'b1;
                waddr = {row, col + cnt[3:0]};
                wdata = blank ? BLANK_CODE : (7'h30 + {3'b000, digit});
            end
            S_CLEAR: begin
                we    = 1'b1;
                waddr = cnt;
                wdata = BLANK_CODE;
            end
            S_FILL: begin
                we    = 1'b1;
                waddr = {row, cnt[3:0]};
                wdata = fill_char;
            end
            default: we = 1'b0;
        endcase
    end

    assign bus.cmd_ready = ready;
    assign bus.busy      = ~ready;
    assign state_dbg     = state;

    // ---------------- counters and conversion datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 8'd0;
            bin_sr    <= 10'd0;
            bcd       <= 12'd0;
            row       <= 4'd0;
            col       <= 4'd0;
            fill_char <= 7'd0;
            nz_seen   <= 1'b0;
        end else begin
            // cnt restarts at every state change, counts inside busy states.
            if (state_nx != state) begin
                cnt <= 8'd0;
            end else if (state != S_IDLE) begin
                cnt <= cnt + 8'd1;
            end

            if (accept) begin
                row       <= bus.cmd_xy[7:4];
                col       <= bus.cmd_xy[3:0];
                fill_char <= bus.cmd_char;
                bin_sr    <= (bus.cmd_num > 10'd999) ? 10'd999 : bus.cmd_num;
                bcd       <= 12'd0;
                nz_seen   <= 1'b0;
            end else if (state == S_CONV) begin
                {bcd, bin_sr} <= {bcd_adjust(bcd), bin_sr} << 1;
            end else if (state == S_WNUM) begin
                nz_seen <= nz_seen | (digit != 4'd0);
            end
        end
    end

    // ---------------- character memory ----------------
    // Writes are suppressed while rst is high so a held reset never touches
    // the buffer (matters when reset parks the FSM in CLEAR).
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; same-address write in the same cycle returns old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_code_q <= 7'd0;
        end else begin
            rd_code_q <= mem[bus.rd_xy];
        end
    end

    assign bus.rd_code = rd_code_q;

endmodule
